// File: rtl/dd_angle_scheduler.sv
// Hall-synchronised angle scheduler for a persistence-of-vision display.
// Optional DD_SCHED_DEGLITCH_EN inserts a stability filter on the synchronised hall signal.
module dd_angle_scheduler #(
    parameter int N_ANGLES        = 16,
    parameter int CNT_WIDTH       = 32,
    parameter int MIN_PERIOD      = 1024,
    parameter int TIMEOUT         = 2**28,
    parameter int DEGLITCH_CYCLES = 4
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESET,
    input  logic                        HALL_IN,
    input  logic                        ENABLE,
    output logic                        ANGLE_STEP,
    output logic                        ANGLE_SYNC,
    output logic [$clog2(N_ANGLES)-1:0] ANGLE_IDX,
    output logic [CNT_WIDTH-1:0]        PERIOD,
    output logic                        LOCKED
);

    localparam int IW = $clog2(N_ANGLES);
    localparam logic [CNT_WIDTH-1:0] MIN_M1 = CNT_WIDTH'(MIN_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] TO_MAX = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] TO_M1 = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_ANGLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t state;
    state_t state_nxt;

    logic hall_s1;
    logic hall_s2;
    logic hall_clean;
    logic hall_d;
    logic hall_rise;

    logic [CNT_WIDTH-1:0] period_cnt;
    logic [CNT_WIDTH-1:0] period_inc;
    logic [CNT_WIDTH-1:0] step_cnt;
    logic [CNT_WIDTH-1:0] step_len;
    logic accept;
    logic timeout;
    logic step_last;
    logic step_fire;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            hall_s1 <= 1'b0;
            hall_s2 <= 1'b0;
        end else begin
            hall_s1 <= HALL_IN;
            hall_s2 <= hall_s1;
        end
    end

`ifdef DD_SCHED_DEGLITCH_EN
    localparam int DW = $clog2(DEGLITCH_CYCLES) + 1;

    logic [DW-1:0] dg_cnt;
    logic          hall_filt;

    // Output follows the input only after DEGLITCH_CYCLES disagreeing samples in a row
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            dg_cnt    <= '0;
            hall_filt <= 1'b0;
        end else if (hall_s2 == hall_filt) begin
            dg_cnt <= '0;
        end else if (dg_cnt == DW'(DEGLITCH_CYCLES - 1)) begin
            dg_cnt    <= '0;
            hall_filt <= hall_s2;
        end else begin
            dg_cnt <= dg_cnt + 1'b1;
        end
    end

    assign hall_clean = hall_filt;
`else
    assign hall_clean = hall_s2;
`endif

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            hall_d    <= 1'b0;
            hall_rise <= 1'b0;
        end else begin
            hall_d    <= hall_clean;
            hall_rise <= hall_clean & ~hall_d;
        end
    end

    assign period_inc = period_cnt + 1'b1;
    assign accept     = (state != IDLE) && hall_rise && (period_cnt >= MIN_M1);
    assign timeout    = (state != IDLE) && (period_cnt >= TO_M1);
    assign step_last  = (step_cnt == step_len - 1'b1);
    // Index saturates so a slowing rotor never wraps the display early
    assign step_fire  = (state == RUN) && !accept && step_last
                        && (ANGLE_IDX != IDX_LAST);

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!ENABLE) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (hall_rise) state_nxt = ARM;
                ARM: begin
                    if (accept) state_nxt = RUN;
                    else if (timeout) state_nxt = IDLE;
                end
                RUN: begin
                    if (accept) state_nxt = RUN;
                    else if (timeout) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        LOCKED = (state == RUN);
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            period_cnt <= '0;
            step_cnt   <= '0;
            step_len   <= '0;
            PERIOD     <= '0;
            ANGLE_IDX  <= '0;
            ANGLE_STEP <= 1'b0;
            ANGLE_SYNC <= 1'b0;
        end else begin
            ANGLE_STEP <= 1'b0;
            ANGLE_SYNC <= 1'b0;
            if (state_nxt == IDLE || state == IDLE) begin
                period_cnt <= '0;
                step_cnt   <= '0;
                step_len   <= '0;
                PERIOD     <= '0;
                ANGLE_IDX  <= '0;
            end else if (accept) begin
                period_cnt <= '0;
                PERIOD     <= period_inc;
                step_len   <= period_inc >> IW;
                step_cnt   <= '0;
                ANGLE_IDX  <= '0;
                ANGLE_SYNC <= 1'b1;
            end else begin
                if (period_cnt != TO_MAX) period_cnt <= period_inc;
                if (state == RUN) begin
                    step_cnt <= step_last ? '0 : step_cnt + 1'b1;
                    if (step_fire) begin
                        ANGLE_STEP <= 1'b1;
                        ANGLE_IDX  <= ANGLE_IDX + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dd_angle_scheduler.sv
// Directed bench for dd_angle_scheduler: lock, slow-down, early edges,
// timeout, async reset, enable and (when built with the filter) deglitch.
module tb_dd_angle_scheduler;

    localparam int NA   = 16;
    localparam int CW   = 32;
    localparam int MINP = 1024;
    localparam int TO   = 5000;
    localparam int DG   = 4;
`ifdef DD_SCHED_DEGLITCH_EN
    localparam int LAT = 4 + DG;
`else
    localparam int LAT = 4;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hall = 1'b0;
    logic          en = 1'b0;
    logic          step;
    logic          sync;
    logic [3:0]    idx;
    logic [CW-1:0] period;
    logic          locked;

    dd_angle_scheduler #(
        .N_ANGLES(NA), .CNT_WIDTH(CW), .MIN_PERIOD(MINP),
        .TIMEOUT(TO), .DEGLITCH_CYCLES(DG)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .HALL_IN(hall), .ENABLE(en),
        .ANGLE_STEP(step), .ANGLE_SYNC(sync), .ANGLE_IDX(idx),
        .PERIOD(period), .LOCKED(locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hold = 0;
    int hlast = 0;
    int hq[$];
    int hw[$];
    int st_q[$];
    int st_i[$];
    int sy_q[$];
    int sy_p[$];
    bit overlap = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (hold > 0) begin
            hold--;
            if (hold == 0) hall = 1'b0;
        end
        if (hq.size() > 0 && hq[0] == cyc) begin
            void'(hq.pop_front());
            hold = hw.pop_front();
            hall = 1'b1;
        end
        if (step) begin
            st_q.push_back(cyc);
            st_i.push_back(int'(idx));
        end
        if (sync) begin
            sy_q.push_back(cyc);
            sy_p.push_back(int'(period));
        end
        if (step && sync) overlap = 1;
    endtask

    task automatic run_to(int target);
        while (cyc < target) tick();
    endtask

    task automatic sched(int c, int w);
        hq.push_back(c);
        hw.push_back(w);
    endtask

    task automatic clr();
        st_q.delete();
        st_i.delete();
        sy_q.delete();
        sy_p.delete();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (locked !== 1'b0 || period !== '0 || idx !== '0 || step !== 1'b0 || sync !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: locked=%b period=%0d idx=%0d step=%b sync=%b, required all 0",
                     locked, period, idx, step, sync);
        end
        rst = 1'b0;
        en = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_lock();
        int c0;
        int s;
        clr();
        c0 = cyc + 5;
        sched(c0, 10);
        sched(c0 + 1600, 10);
        sched(c0 + 3200, 10);
        run_to(c0 + 1600 + LAT - 1);
        checks++;
        if (sy_q.size() != 0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL arm_only: syncs=%0d locked=%b, required 0 and 0", sy_q.size(), locked);
        end
        tick();
        checks++;
        if (sync !== 1'b1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL sync_latency: sync=%b locked=%b at %0d clocks, required 1 and 1", sync, locked, LAT);
        end
        checks++;
        if (period !== 1600 || idx !== 0) begin
            failures++;
            $display("FAIL lock_period: period=%0d idx=%0d, required 1600 and 0", period, idx);
        end
        s = cyc;
        run_to(s + 1600);
        checks++;
        if (st_q.size() != 15) begin
            failures++;
            $display("FAIL step_count: got %0d, required 15", st_q.size());
        end
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (k >= st_q.size() || st_q[k] != s + 100 * (k + 1) || st_i[k] != k + 1) begin
                failures++;
                $display("FAIL step_%0d: cyc=%0d idx=%0d, required cyc=%0d idx=%0d", k,
                         (k < st_q.size()) ? st_q[k] : -1, (k < st_i.size()) ? st_i[k] : -1,
                         s + 100 * (k + 1), k + 1);
            end
        end
        checks++;
        if (sync !== 1'b1 || idx !== 0 || period !== 1600 || sy_q.size() != 2) begin
            failures++;
            $display("FAIL resync: sync=%b idx=%0d period=%0d syncs=%0d, required 1 0 1600 2",
                     sync, idx, period, sy_q.size());
        end
        hlast = c0 + 3200;
    endtask

    task automatic test_slowdown();
        int s2;
        int s3;
        s2 = cyc;
        sched(hlast + 2000, 10);
        clr();
        run_to(s2 + 2000);
        checks++;
        if (st_q.size() != 15 || st_q[14] != s2 + 1500 || st_i[14] != 15) begin
            failures++;
            $display("FAIL slow_hold: steps=%0d, required 15 with last at +1500 idx 15", st_q.size());
        end
        checks++;
        if (sy_q.size() != 1 || sy_q[0] != s2 + 2000 || sy_p[0] != 2000) begin
            failures++;
            $display("FAIL slow_resync: syncs=%0d, required one at +2000 with period 2000", sy_q.size());
        end
        hlast = hlast + 2000;
        s3 = cyc;
        clr();
        run_to(s3 + 250);
        checks++;
        if (st_q.size() != 2 || st_q[0] != s3 + 125 || st_q[1] != s3 + 250) begin
            failures++;
            $display("FAIL slow_spacing: steps=%0d first=%0d, required 2 at +125 and +250",
                     st_q.size(), (st_q.size() > 0) ? st_q[0] - s3 : -1);
        end
    endtask

    task automatic test_ignore();
        int s3;
        s3 = hlast + LAT;
        sched(hlast + 300, 10);
        sched(hlast + 2000, 10);
        clr();
        run_to(s3 + 1999);
        checks++;
        if (sy_q.size() != 0 || period !== 2000 || locked !== 1'b1) begin
            failures++;
            $display("FAIL early_edge: syncs=%0d period=%0d locked=%b, required 0 2000 1",
                     sy_q.size(), period, locked);
        end
        checks++;
        if (st_q.size() != 13 || st_q[0] != s3 + 375 || st_q[12] != s3 + 1875) begin
            failures++;
            $display("FAIL early_stepping: steps=%0d, required 13 from +375 to +1875", st_q.size());
        end
        tick();
        checks++;
        if (sync !== 1'b1 || period !== 2000) begin
            failures++;
            $display("FAIL early_next_sync: sync=%b period=%0d, required 1 2000", sync, period);
        end
        hlast = hlast + 2000;
    endtask

    task automatic test_timeout();
        int s4;
        s4 = cyc;
        clr();
        run_to(s4 + TO - 1);
        checks++;
        if (locked !== 1'b1 || st_q.size() != 15) begin
            failures++;
            $display("FAIL pre_timeout: locked=%b steps=%0d, required 1 15", locked, st_q.size());
        end
        tick();
        checks++;
        if (locked !== 1'b0 || period !== 0 || idx !== 0) begin
            failures++;
            $display("FAIL timeout: locked=%b period=%0d idx=%0d, required 0 0 0", locked, period, idx);
        end
        clr();
        repeat (300) tick();
        checks++;
        if (st_q.size() != 0 || sy_q.size() != 0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL post_timeout: steps=%0d syncs=%0d locked=%b, required 0 0 0",
                     st_q.size(), sy_q.size(), locked);
        end
    endtask

    task automatic test_reset_mid();
        int h;
        int s;
        h = cyc + 5;
        sched(h, 10);
        sched(h + 1600, 10);
        sched(h + 3200, 10);
        sched(h + 4800, 10);
        run_to(h + 1600 + LAT);
        checks++;
        if (sync !== 1'b1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL relock: sync=%b locked=%b, required 1 1", sync, locked);
        end
        s = cyc;
        run_to(s + 700);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (locked !== 1'b0 || period !== '0 || idx !== '0 || step !== 1'b0 || sync !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: locked=%b period=%0d idx=%0d step=%b sync=%b, required all 0",
                     locked, period, idx, step, sync);
        end
        tick();
        tick();
        rst = 1'b0;
        clr();
        run_to(h + 3200 + LAT + 5);
        checks++;
        if (sy_q.size() != 0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_arm_only: syncs=%0d locked=%b, required 0 0", sy_q.size(), locked);
        end
        run_to(h + 4800 + LAT);
        checks++;
        if (sync !== 1'b1 || locked !== 1'b1 || period !== 1600) begin
            failures++;
            $display("FAIL reset_relock: sync=%b locked=%b period=%0d, required 1 1 1600",
                     sync, locked, period);
        end
    endtask

    task automatic test_enable();
        en = 1'b0;
        tick();
        checks++;
        if (locked !== 1'b0 || period !== '0 || idx !== '0 || step !== 1'b0 || sync !== 1'b0) begin
            failures++;
            $display("FAIL disable: locked=%b period=%0d idx=%0d step=%b sync=%b, required all 0",
                     locked, period, idx, step, sync);
        end
        clr();
        repeat (200) tick();
        checks++;
        if (st_q.size() != 0 || sy_q.size() != 0) begin
            failures++;
            $display("FAIL disable_quiet: steps=%0d syncs=%0d, required 0 0", st_q.size(), sy_q.size());
        end
        en = 1'b1;
        repeat (4) tick();
    endtask

`ifdef DD_SCHED_DEGLITCH_EN
    task automatic test_deglitch();
        int h;
        h = cyc + 5;
        sched(h, 2);
        sched(h + 1600, 10);
        sched(h + 3200, 10);
        clr();
        run_to(h + 3200 + LAT - 1);
        checks++;
        if (sy_q.size() != 0 || sync !== 1'b0) begin
            failures++;
            $display("FAIL glitch_ignored: syncs=%0d, required 0", sy_q.size());
        end
        tick();
        checks++;
        if (sync !== 1'b1 || period !== 1600) begin
            failures++;
            $display("FAIL deglitch_latency: sync=%b period=%0d, required 1 1600", sync, period);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock();
        test_slowdown();
        test_ignore();
        test_timeout();
        test_reset_mid();
        test_enable();
`ifdef DD_SCHED_DEGLITCH_EN
        test_deglitch();
`endif
        checks++;
        if (overlap !== 1'b0) begin
            failures++;
            $display("FAIL pulse_overlap: seen=%b, required 0", overlap);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
